// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and captured-operation record for alu_arbiter.
// Pure declarations: no latency and no flow control of its own.
// Backpressure: none.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_BEQ = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    function automatic logic op_legal(input logic [2:0] op);
        return !(op == 3'b011 || op == 3'b101);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: AND, OR, ADD, SUB, unsigned SLT; zero flags an all-zero result.
// Latency: zero cycles (purely combinational).
// Backpressure: none.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {31'd0, (a < b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU through an IDLE/EXEC/RESP sequencer.
// Latency: accept in cycle T, response valid in cycle T+2; one operation per 3 cycles at best.
// Backpressure: requests wait outside IDLE; the response is held until its rsp_ready.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,
    output logic        rsp1_err,
    output logic        busy
);

    state_t      state_q, state_d;
    alu_req_t    cap_q, req_sel;
    logic        grant_q, grant_d, ptr_q;
    logic [31:0] result_q;
    logic        zero_q, err_q;
    logic        any_req, accept, rsp_done;

    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        is_beq, exec_err;
    logic [31:0] exec_result;
    logic        exec_zero;

    assign any_req = req0_valid | req1_valid;
    assign accept  = (state_q == ST_IDLE) && any_req;

    // The pointer only breaks ties; a lone requester always wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_d = (PRIO_MODE != 0) ? 1'b0 : ptr_q;
        end else begin
            grant_d = req1_valid;
        end
    end

    always_comb begin
        req_sel = '0;
        if (grant_d) begin
            req_sel.op = req1_op;
            req_sel.a  = req1_a;
            req_sel.b  = req1_b;
        end else begin
            req_sel.op = req0_op;
            req_sel.a  = req0_a;
            req_sel.b  = req0_b;
        end
    end

    assign req0_ready = rst_n && accept && !grant_d;
    assign req1_ready = rst_n && accept &&  grant_d;

    assign rsp_done = (state_q == ST_RESP) && (grant_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req)  state_d = ST_EXEC;
            ST_EXEC:               state_d = ST_RESP;
            ST_RESP: if (rsp_done) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // BEQ reuses the subtractor: a - b is zero exactly when a == b.
    assign is_beq   = (cap_q.op == ALU_BEQ);
    assign exec_err = !op_legal(cap_q.op);
    assign alu_op   = is_beq ? ALU_SUB : cap_q.op;

    alu u_alu (
        .a      (cap_q.a),
        .b      (cap_q.b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign exec_result = (is_beq || exec_err) ? '0 : alu_result;
    assign exec_zero   = is_beq && alu_zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b0;
            ptr_q    <= 1'b0;
            cap_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= grant_d;
                cap_q   <= req_sel;
            end
            if (state_q == ST_EXEC) begin
                result_q <= exec_result;
                zero_q   <= exec_zero;
                err_q    <= exec_err;
            end
            if (rsp_done) begin
                ptr_q <= ~grant_q;
            end
        end
    end

    assign rsp0_valid  = (state_q == ST_RESP) && !grant_q;
    assign rsp1_valid  = (state_q == ST_RESP) &&  grant_q;
    assign rsp0_result = rsp0_valid ? result_q : '0;
    assign rsp1_result = rsp1_valid ? result_q : '0;
    assign rsp0_zero   = rsp0_valid && zero_q;
    assign rsp1_zero   = rsp1_valid && zero_q;
    assign rsp0_err    = rsp0_valid && err_q;
    assign rsp1_err    = rsp1_valid && err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, arbitration/stall/reset sequences, random traffic vs a reference model.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0][2:0]  req_op;
    wire  [1:0]       req_ready;
    wire  [1:0]       rsp_valid;
    wire  [1:0][31:0] rsp_result;
    wire  [1:0]       rsp_zero;
    wire  [1:0]       rsp_err;
    wire              busy;

    int vectors     = 0;
    int miscompares = 0;
    int rr_next     = 0;

    alu_arbiter #(.PRIO_MODE(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req_valid[0]),
        .req0_ready  (req_ready[0]),
        .req0_a      (req_a[0]),
        .req0_b      (req_b[0]),
        .req0_op     (req_op[0]),
        .req1_valid  (req_valid[1]),
        .req1_ready  (req_ready[1]),
        .req1_a      (req_a[1]),
        .req1_b      (req_b[1]),
        .req1_op     (req_op[1]),
        .rsp0_valid  (rsp_valid[0]),
        .rsp0_ready  (rsp_ready[0]),
        .rsp0_result (rsp_result[0]),
        .rsp0_zero   (rsp_zero[0]),
        .rsp0_err    (rsp_err[0]),
        .rsp1_valid  (rsp_valid[1]),
        .rsp1_ready  (rsp_ready[1]),
        .rsp1_result (rsp_result[1]),
        .rsp1_zero   (rsp_zero[1]),
        .rsp1_err    (rsp_err[1]),
        .busy        (busy)
    );

    typedef struct {
        int          n;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU straight from the opcode table.
    task automatic ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic z, output logic e);
        r = '0;
        z = 1'b0;
        e = 1'b0;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a + b;
            3'b110:  r = a - b;
            3'b111:  r = (a < b) ? 32'd1 : 32'd0;
            3'b100:  z = (a == b);
            default: e = 1'b1;
        endcase
    endtask

    task automatic drive(input int n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[n]    = op;
        req_a[n]     = a;
        req_b[n]     = b;
        req_valid[n] = 1'b1;
    endtask

    task automatic rand_req(input int n);
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        if ($urandom_range(0, 1) == 1) begin
            a = a & 32'hF;
            b = b & 32'hF;
        end
        drive(n, 3'($urandom_range(0, 7)), a, b);
    endtask

    // Called in an IDLE cycle after the negedge with requests already driven; winner w is expected.
    task automatic serve(input int w, input int stall, input logic [31:0] er, input logic ez, input logic ee);
        int o;
        o = 1 - w;
        #1;
        chk("grant_ready", req_ready[w], 1);
        chk("loser_ready", req_ready[o], 0);
        @(negedge clk);
        req_valid[w] = 1'b0;
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_req_ready", req_ready, 0);
        @(negedge clk);
        #1;
        chk("rsp_valid_t2", rsp_valid, (w == 1) ? 2'b10 : 2'b01);
        chk("rsp_result", rsp_result[w], er);
        chk("rsp_zero", rsp_zero[w], ez);
        chk("rsp_err", rsp_err[w], ee);
        chk("other_rsp_result", rsp_result[o], 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            #1;
            chk("stall_rsp_valid", rsp_valid[w], 1);
            chk("stall_result", rsp_result[w], er);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_busy", busy, 1);
        end
        rsp_ready[w] = 1'b1;
        @(negedge clk);
        rsp_ready[w] = 1'b0;
        #1;
        chk("done_busy", busy, 0);
        chk("done_rsp_valid", rsp_valid, 0);
        rr_next = o;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er;
        logic        ez;
        logic        ee;
        int          w;

        tbl[0]  = '{0, 3'b010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        tbl[1]  = '{1, 3'b000, 32'hF0F0_FF00,  32'h0FF0_0F0F,  32'h00F0_0F00,  1'b0, 1'b0};
        tbl[2]  = '{0, 3'b001, 32'hF0F0_0000,  32'h0000_000F,  32'hF0F0_000F,  1'b0, 1'b0};
        tbl[3]  = '{1, 3'b010, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0, 1'b0};
        tbl[4]  = '{0, 3'b110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};
        tbl[5]  = '{1, 3'b111, 32'd2,          32'd9,          32'd1,          1'b0, 1'b0};
        tbl[6]  = '{0, 3'b111, 32'd9,          32'd2,          32'd0,          1'b0, 1'b0};
        tbl[7]  = '{1, 3'b111, 32'h8000_0000,  32'd1,          32'd0,          1'b0, 1'b0};
        tbl[8]  = '{0, 3'b100, 32'h55,         32'h55,         32'd0,          1'b1, 1'b0};
        tbl[9]  = '{1, 3'b100, 32'd1,          32'd2,          32'd0,          1'b0, 1'b0};
        tbl[10] = '{1, 3'b011, 32'd3,          32'd4,          32'd0,          1'b0, 1'b1};
        tbl[11] = '{1, 3'b010, 32'd3,          32'd4,          32'd7,          1'b0, 1'b0};
        tbl[12] = '{0, 3'b101, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b1};
        tbl[13] = '{0, 3'b110, 32'd7,          32'd7,          32'd0,          1'b0, 1'b0};

        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp0_result", rsp_result[0], 0);
        chk("reset_rsp1_result", rsp_result[1], 0);
        chk("reset_flags", {rsp_zero, rsp_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both valid after reset: req0 first, then req1, then req0 again when both re-assert.
        drive(0, 3'b110, 32'd10, 32'd3);
        drive(1, 3'b111, 32'd2, 32'd9);
        serve(0, 0, 32'd7, 1'b0, 1'b0);
        serve(1, 0, 32'd1, 1'b0, 1'b0);
        drive(0, 3'b010, 32'd1, 32'd1);
        drive(1, 3'b010, 32'd2, 32'd2);
        serve(0, 0, 32'd2, 1'b0, 1'b0);
        drive(0, 3'b001, 32'd8, 32'd1);
        serve(1, 0, 32'd4, 1'b0, 1'b0);
        serve(0, 0, 32'd9, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].n, tbl[i].op, tbl[i].a, tbl[i].b);
            serve(tbl[i].n, 0, tbl[i].res, tbl[i].zero, tbl[i].err);
        end

        // Stalled response holds the other requester off until the handshake.
        drive(0, 3'b010, 32'd100, 32'd23);
        drive(1, 3'b001, 32'h0F00, 32'h00F0);
        w = rr_next;
        ref_alu(req_op[w], req_a[w], req_b[w], er, ez, ee);
        serve(w, 5, er, ez, ee);
        w = 1 - w;
        ref_alu(req_op[w], req_a[w], req_b[w], er, ez, ee);
        serve(w, 0, er, ez, ee);

        for (int it = 0; it < 60; it++) begin
            for (int n = 0; n < 2; n++) begin
                if (!req_valid[n] && $urandom_range(0, 1) == 1) rand_req(n);
            end
            if (req_valid == 2'b00) rand_req(int'($urandom_range(0, 1)));
            w = (req_valid == 2'b11) ? rr_next : (req_valid[1] ? 1 : 0);
            ref_alu(req_op[w], req_a[w], req_b[w], er, ez, ee);
            serve(w, int'($urandom_range(0, 2)), er, ez, ee);
        end
        for (int k = 0; k < 2; k++) begin
            if (req_valid != 2'b00) begin
                w = req_valid[1] ? 1 : 0;
                ref_alu(req_op[w], req_a[w], req_b[w], er, ez, ee);
                serve(w, 0, er, ez, ee);
            end
        end

        // Reset during EXEC drops the operation and returns the pointer to requester 0.
        drive(0, 3'b010, 32'd1, 32'd1);
        serve(0, 0, 32'd2, 1'b0, 1'b0);
        drive(0, 3'b010, 32'd1, 32'd2);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("pre_reset_exec_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        rr_next = 0;
        #1;
        chk("post_reset_busy", busy, 0);
        chk("post_reset_rsp_valid", rsp_valid, 0);
        chk("post_reset_req_ready", req_ready, 0);
        chk("post_reset_result", rsp_result[0] | rsp_result[1], 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("no_ghost_rsp", rsp_valid, 0);
            chk("no_ghost_busy", busy, 0);
        end
        drive(0, 3'b000, 32'hFF, 32'h0F);
        drive(1, 3'b001, 32'hF0, 32'h0F);
        serve(0, 0, 32'h0F, 1'b0, 1'b0);
        serve(1, 0, 32'hFF, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
